// File: rtl/alu_scalar_pkg.sv
// ============================================================================
// alu_scalar_pkg : shared state encoding, group count and saturation limits
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_scalar_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Number of LANES-wide groups needed to cover n_elems elements.
    function automatic int num_groups(input int n_elems, input int lanes);
        return (n_elems + lanes - 1) / lanes;
    endfunction

    function automatic logic [63:0] sat_pos(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_neg(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/scalar_mul_lane.sv
// ============================================================================
// scalar_mul_lane : one DATA_W x DATA_W signed multiply with overflow detect;
// clamps instead of wrapping when ALU_SCALAR_SATURATE_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module scalar_mul_lane
    import alu_scalar_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              overflow
);

    logic signed [2*DATA_W-1:0] a_ext;
    logic signed [2*DATA_W-1:0] b_ext;
    logic signed [2*DATA_W-1:0] product;

    assign a_ext   = {{DATA_W{a[DATA_W-1]}}, a};
    assign b_ext   = {{DATA_W{b[DATA_W-1]}}, b};
    assign product = a_ext * b_ext;

    // The upper half must be pure sign extension of the low half's MSB.
    assign overflow = (product[2*DATA_W-1:DATA_W] != {DATA_W{product[DATA_W-1]}});

`ifdef ALU_SCALAR_SATURATE_EN
    localparam logic [DATA_W-1:0] SAT_MAX = DATA_W'(sat_pos(DATA_W));
    localparam logic [DATA_W-1:0] SAT_MIN = DATA_W'(sat_neg(DATA_W));

    assign result = !overflow             ? product[DATA_W-1:0] :
                    product[2*DATA_W-1]   ? SAT_MIN : SAT_MAX;
`else
    assign result = product[DATA_W-1:0];
`endif

endmodule

`default_nettype wire

// File: rtl/alu_scalar_seq_module.sv
// ============================================================================
// alu_scalar_seq_module : sequential scalar x matrix multiply, LANES elements
// per cycle under a start/done handshake. Optional macro: ALU_SCALAR_SATURATE_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_scalar_seq_module
    import alu_scalar_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int N_ELEMS = 25,
    parameter int LANES   = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [N_ELEMS*DATA_W-1:0] A_flat,
    input  logic [DATA_W-1:0]         scalar,
    output logic                      busy,
    output logic                      done,
    output logic [N_ELEMS*DATA_W-1:0] C_flat,
    output logic [N_ELEMS-1:0]        overflow_vec,
    output logic                      overflow_flag
);

    localparam int G     = num_groups(N_ELEMS, LANES);
    localparam int IDX_W = (G > 1) ? $clog2(G) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(G - 1);

    logic [1:0]                state;
    logic [IDX_W-1:0]          idx;
    logic [N_ELEMS*DATA_W-1:0] a_reg;
    logic [DATA_W-1:0]         scalar_reg;

    logic [DATA_W-1:0] lane_opts [LANES][G];
    logic [DATA_W-1:0] lane_res  [LANES];
    logic [LANES-1:0]  lane_ovf;

    // Lanes beyond N_ELEMS in the last group see zero; their outputs are never stored.
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        for (genvar g = 0; g < G; g++) begin : g_grp
            if (g * LANES + j < N_ELEMS) begin : g_valid
                assign lane_opts[j][g] = a_reg[(g*LANES+j)*DATA_W +: DATA_W];
            end else begin : g_pad
                assign lane_opts[j][g] = '0;
            end
        end

        scalar_mul_lane #(
            .DATA_W (DATA_W)
        ) u_lane (
            .a        (lane_opts[j][idx]),
            .b        (scalar_reg),
            .result   (lane_res[j]),
            .overflow (lane_ovf[j])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            idx          <= '0;
            a_reg        <= '0;
            scalar_reg   <= '0;
            C_flat       <= '0;
            overflow_vec <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_reg        <= A_flat;
                        scalar_reg   <= scalar;
                        C_flat       <= '0;
                        overflow_vec <= '0;
                        idx          <= '0;
                        state        <= ST_RUN;
                    end else begin
                        state        <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    for (int i = 0; i < N_ELEMS; i++) begin
                        if (idx == IDX_W'(i / LANES)) begin
                            C_flat[i*DATA_W +: DATA_W] <= lane_res[i % LANES];
                            overflow_vec[i]            <= lane_ovf[i % LANES];
                        end
                    end
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        state <= ST_DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy          = (state == ST_RUN);
    assign done          = (state == ST_DONE);
    assign overflow_flag = |overflow_vec;

endmodule

`default_nettype wire

// File: tb/tb_alu_scalar_seq_module.sv
// ============================================================================
// tb_alu_scalar_seq_module : directed checks of the default 5-lane build and a
// 4-lane partial-group build driven by the same stimulus.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_scalar_seq_module;

    localparam int W = 8;
    localparam int N = 25;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic             start  = 1'b0;
    logic [N*W-1:0]   A_flat = '0;
    logic [W-1:0]     scalar = '0;

    logic             busy1, done1, of1;
    logic [N*W-1:0]   c1;
    logic [N-1:0]     ov1;
    logic             busy2, done2, of2;
    logic [N*W-1:0]   c2;
    logic [N-1:0]     ov2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_scalar_seq_module #(.DATA_W(W), .N_ELEMS(N), .LANES(5)) u_dut5 (
        .clk (clk), .rst_n (rst_n), .start (start), .A_flat (A_flat), .scalar (scalar),
        .busy (busy1), .done (done1), .C_flat (c1), .overflow_vec (ov1), .overflow_flag (of1)
    );

    alu_scalar_seq_module #(.DATA_W(W), .N_ELEMS(N), .LANES(4)) u_dut4 (
        .clk (clk), .rst_n (rst_n), .start (start), .A_flat (A_flat), .scalar (scalar),
        .busy (busy2), .done (done2), .C_flat (c2), .overflow_vec (ov2), .overflow_flag (of2)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [N*W-1:0] exp_c(input logic [N*W-1:0] a, input logic [W-1:0] s);
        logic [N*W-1:0] r;
        int p;
        r = '0;
        for (int i = 0; i < N; i++) begin
            p = int'($signed(a[i*W +: W])) * int'($signed(s));
`ifdef ALU_SCALAR_SATURATE_EN
            if (p > 127) p = 127;
            else if (p < -128) p = -128;
`endif
            r[i*W +: W] = p[7:0];
        end
        return r;
    endfunction

    function automatic logic [N-1:0] exp_ov(input logic [N*W-1:0] a, input logic [W-1:0] s);
        logic [N-1:0] r;
        int p;
        r = '0;
        for (int i = 0; i < N; i++) begin
            p = int'($signed(a[i*W +: W])) * int'($signed(s));
            r[i] = (p > 127) || (p < -128);
        end
        return r;
    endfunction

    function automatic logic [N*W-1:0] fill(input logic [W-1:0] v);
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = v;
        return r;
    endfunction

    task automatic start_op(input logic [N*W-1:0] a, input logic [W-1:0] s);
        @(negedge clk);
        A_flat = a;
        scalar = s;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Waits for both DUTs' done pulses, recording latency and busy-cycle counts.
    task automatic wait_both(output int lat1, output int lat2, output int bc1);
        bit seen1 = 0, seen2 = 0;
        int cyc = 0;
        lat1 = -1; lat2 = -1; bc1 = 0;
        while (!(seen1 && seen2) && cyc < 64) begin
            if (busy1) bc1++;
            if (done1 && !seen1) begin seen1 = 1; lat1 = cyc; end
            if (done2 && !seen2) begin seen2 = 1; lat2 = cyc; end
            if (!(seen1 && seen2)) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!(seen1 && seen2)) check("done_timeout", 256'({seen1, seen2}), 256'(2'b11));
    endtask

    task automatic run_check(input string tag, input logic [N*W-1:0] a, input logic [W-1:0] s);
        int lat1, lat2, bc1;
        start_op(a, s);
        wait_both(lat1, lat2, bc1);
        check({tag, "_c5"},   256'(c1),  256'(exp_c(a, s)));
        check({tag, "_ov5"},  256'(ov1), 256'(exp_ov(a, s)));
        check({tag, "_of5"},  256'(of1), 256'(|exp_ov(a, s)));
        check({tag, "_lat5"}, 256'(lat1), 256'(5));
        check({tag, "_busy5"}, 256'(bc1), 256'(5));
        check({tag, "_c4"},   256'(c2),  256'(exp_c(a, s)));
        check({tag, "_ov4"},  256'(ov2), 256'(exp_ov(a, s)));
        check({tag, "_lat4"}, 256'(lat2), 256'(7));
    endtask

    initial begin
        logic [N*W-1:0] a_v;
        logic [N*W-1:0] a_x;
        int cyc;
        bit any_done;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_outputs", 256'({busy1, done1, of1, ov1, c1}), 256'(0));
        check("rst_outputs4", 256'({busy2, done2, of2, ov2, c2}), 256'(0));
        rst_n = 1'b1;

        // Abort mid-RUN with an asynchronous reset
        start_op(fill(8'd1), 8'd3);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("abort_outputs", 256'({busy1, done1, of1, ov1, c1}), 256'(0));
        any_done = 0;
        repeat (8) begin
            @(negedge clk);
            if (done1 || done2) any_done = 1;
        end
        check("abort_no_done", 256'(any_done), 256'(0));
        rst_n = 1'b1;

        run_check("ones_x3", fill(8'd1), 8'd3);
        check("ones_x3_elem", 256'(c1[7:0]), 256'(8'd3));

        for (int i = 0; i < N; i++) a_v[i*W +: W] = 8'(i - 12);
        run_check("ramp_x5", a_v, 8'd5);
        check("ramp_x5_e0", 256'(c1[7:0]), 256'(8'hC4));
        check("ramp_x5_e24", 256'(c1[199:192]), 256'(8'h3C));

        a_v = fill(8'd1);
        a_v[7:0]     = 8'd100;
        a_v[199:192] = 8'h80;
        run_check("ovf_x2", a_v, 8'd2);
        check("ovf_vec_bits", 256'(ov1), 256'(25'h1000001));
`ifdef ALU_SCALAR_SATURATE_EN
        check("ovf_e0", 256'(c1[7:0]), 256'(8'h7F));
        check("ovf_e24", 256'(c1[199:192]), 256'(8'h80));
        check("ovf_e24_l4", 256'(c2[199:192]), 256'(8'h80));
`else
        check("ovf_e0", 256'(c1[7:0]), 256'(8'hC8));
        check("ovf_e24", 256'(c1[199:192]), 256'(8'h00));
        check("ovf_e24_l4", 256'(c2[199:192]), 256'(8'h00));
`endif
        check("ovf_e1", 256'(c1[15:8]), 256'(8'h02));

        run_check("min_xm1", fill(8'h80), 8'hFF);
        check("min_xm1_vec", 256'(ov1), 256'(25'h1FFFFFF));
`ifdef ALU_SCALAR_SATURATE_EN
        check("min_xm1_e7", 256'(c1[63:56]), 256'(8'h7F));
`else
        check("min_xm1_e7", 256'(c1[63:56]), 256'(8'h80));
`endif

        for (int i = 0; i < N; i++) a_v[i*W +: W] = 8'(i * 9 - 100);
        run_check("any_x0", a_v, 8'd0);
        check("any_x0_flag", 256'(of1), 256'(0));

        // Handshake: ignored start during RUN, input change, back-to-back start in DONE
        for (int i = 0; i < N; i++) a_x[i*W +: W] = 8'(i);
        start_op(a_x, 8'd2);
        A_flat = fill(8'd7);
        scalar = 8'd7;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cyc = 0;
        while (!done1 && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        check("hs_first_done", 256'(done1), 256'(1));
        check("hs_first_c", 256'(c1), 256'(exp_c(a_x, 8'd2)));
        check("hs_first_e24", 256'(c1[199:192]), 256'(8'd48));
        A_flat = fill(8'hFD);
        scalar = 8'd4;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        A_flat = fill(8'd55);
        check("hs_no_bubble", 256'({busy1, done1}), 256'(2'b10));
        cyc = 0;
        while (!done1 && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        check("hs_b2b_spacing", 256'(cyc + 1), 256'(6));
        check("hs_second_c", 256'(c1), 256'(fill(8'hF4)));
        repeat (10) @(negedge clk);
        check("hs_l4_ignored", 256'(c2), 256'(exp_c(a_x, 8'd2)));
        check("hs_idle", 256'({busy1, done1, busy2, done2}), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
